tmds_encoder: RTL and testbench
===============================

# tmds_encoder

Full DVI/HDMI TMDS channel encoder: takes one 8-bit colour component per pixel clock plus two control bits and a video-data-enable flag, and produces the 10-bit DC-balanced TMDS symbol for one channel. It instantiates `tmds_choice` for transition minimisation and adds the stateful second stage: a running disparity tally, DC-balancing inversion and control-token insertion. Three instances, one per colour channel, sit between the video timing/pixel pipeline and the 10:1 serializer.

## Interface
- No parameters.
- `clk_in`  input  1  pixel clock; all state updates on rising edge.
- `rst_in`  input  1  reset; asynchronous, active-high.
- `data_in`  input  8  pixel component; sampled every cycle.
- `control_in`  input  2  control bits {C1,C0}; used when `ve_in`=0.
- `ve_in`  input  1  video data enable; 1 = encode `data_in`, 0 = emit control token.
- `tmds_out`  output  10  encoded symbol, bit 0 transmitted first; registered.
- `tally_out`  output  5  signed running disparity after the symbol on `tmds_out`; registered.

## Operation
- Stage 1 (register): `qm_r` ← `tmds_choice` result for `data_in` (9 bits); `ve_r` ← `ve_in`; `ctrl_r` ← `control_in`.
- Stage 2 (register), from stage-1 registers:
  - N1 = popcount(`qm_r`[7:0]), N0 = 8 − N1; tally T is 5-bit two's complement.
  - `ve_r`=0: T ← 0; `tmds_out` ← token: 00 → 10'b1101010100, 01 → 10'b0010101011, 10 → 10'b0101010100, 11 → 10'b1010101011 (index = {C1,C0}).
  - `ve_r`=1, case A (T==0 or N1==N0): out[9]=~qm[8], out[8]=qm[8], out[7:0]= qm[8] ? qm[7:0] : ~qm[7:0]; T ← T + (qm[8] ? N1−N0 : N0−N1).
  - `ve_r`=1, case B ((T>0 and N1>N0) or (T<0 and N0>N1)): out = {1, qm[8], ~qm[7:0]}; T ← T + 2·qm[8] + (N0−N1).
  - `ve_r`=1, otherwise: out = {0, qm[8], qm[7:0]}; T ← T − 2·(~qm[8]) + (N1−N0).
- All tally arithmetic signed, computed at ≥6 bits then truncated to 5; correct encoding keeps |T| ≤ 10, so no saturation logic.
- `tally_out` = T after the update.

## Timing
- Latency 2 cycles: inputs sampled at edge k appear on `tmds_out` after edge k+1. Throughput one symbol per cycle; no stall, no handshake.
- Reset (async assert, any time): `qm_r`=0, `ve_r`=0, `ctrl_r`=0, `tmds_out`=10'b0, `tally_out`=0. Outputs go to 0 immediately on assertion, not at next edge.
- First edge after deassert: `tmds_out` = 10'b1101010100 (stage 1 holds ve=0, ctrl=00), T=0.
- Reset mid-active-video: tally discarded; encoding restarts from T=0.
- `ve_in` 1→0: token emitted 2 cycles later, T forced 0 in the same update. 0→1: first data symbol uses T=0 (case A).
- `control_in` ignored while `ve_in`=1; `data_in` ignored while `ve_in`=0.

## Test plan
- Reset: assert `rst_in` mid-stream → `tmds_out`=0, `tally_out`=0 same cycle; one edge after release → 10'h354 (10'b1101010100).
- Control tokens: `ve_in`=0, `control_in`=00,01,10,11 on consecutive cycles → after 2-cycle latency 10'h354, 10'h0AB, 10'h154, 10'h2AB; `tally_out`=0 throughout.
- Balancing on zeros: from T=0, `ve_in`=1, `data_in`=8'h00 twice → 10'h100 (T=−8), then 10'h3FF (T=+2).
- All ones: from T=0, `data_in`=8'hFF → 10'h200, T=−8; following 8'hFF with T=−8 → case else branch, out 10'h0FF, T=−8−2+8=−2.
- Random soak: ≥10^5 random `data_in`/`ve_in` values vs. behavioural model of the above equations → exact match on `tmds_out` and `tally_out`; |T| ≤ 10 always; reference decoder recovers `data_in` and control bits.
- Boundary: alternate `ve_in` each cycle with 8'hFF/control 11 → data symbols always use case A from T=0 (10'h200), tokens 10'h2AB, tally returns to 0 on every token.

Source files
------------

// File: rtl/tmds_encoder_if.sv
// tmds_encoder_if
// Groups the pixel-side inputs and the encoded-symbol outputs of one TMDS
// channel encoder.
//   data_in    [7:0]  pixel colour component
//   control_in [1:0]  control bits {C1,C0}, meaningful while ve_in = 0
//   ve_in             video data enable (1 = pixel data, 0 = control token)
//   tmds_out   [9:0]  encoded symbol, bit 0 transmitted first
//   tally_out  [4:0]  signed running disparity after the symbol on tmds_out
// master: pixel pipeline side (drives data/control, reads the symbol)
// slave : encoder side
interface tmds_encoder_if;
    logic [7:0] data_in;
    logic [1:0] control_in;
    logic       ve_in;
    logic [9:0] tmds_out;
    logic [4:0] tally_out;

    modport master (
        output data_in, control_in, ve_in,
        input  tmds_out, tally_out
    );

    modport slave (
        input  data_in, control_in, ve_in,
        output tmds_out, tally_out
    );
endinterface

// File: rtl/tmds_encoder.sv
// tmds_encoder
// DVI/HDMI TMDS channel encoder. Stage 1 registers the transition-minimised
// 9-bit word from tmds_choice together with the enable and control bits.
// Stage 2 applies DC balancing against the running disparity tally, or
// inserts a control token during blanking.
// Ports:
//   clk_in   pixel clock, rising edge
//   rst_in   asynchronous, active-high reset
//   bus      tmds_encoder_if.slave (data_in, control_in, ve_in -> tmds_out, tally_out)

// tmds_choice
// Transition-minimising first stage: XOR or XNOR chain over the data bits,
// picking XNOR when the byte has more than four ones (or exactly four with
// bit 0 clear). qm_o[8] = 1 marks the XOR encoding.
//   data_i [7:0]  input byte
//   qm_o   [8:0]  transition-minimised word
module tmds_choice (
    input  logic [7:0] data_i,
    output logic [8:0] qm_o
);
    logic [3:0] ones;
    logic       use_xnor;
    logic [7:0] q;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, data_i[i]};
        end
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data_i[0]);
        q        = '0;
        q[0]     = data_i[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ data_i[i]) : (q[i-1] ^ data_i[i]);
        end
        qm_o = {~use_xnor, q};
    end
endmodule

module tmds_encoder (
    input  logic          clk_in,
    input  logic          rst_in,
    tmds_encoder_if.slave bus
);
    logic [8:0] qm_d;
    logic [8:0] qm_q;
    logic       ve_q;
    logic [1:0] ctrl_q;
    logic [9:0] tmds_d;
    logic [9:0] tmds_q;
    logic [4:0] tally_d;
    logic [4:0] tally_q;

    logic [3:0]        n1;
    logic signed [5:0] t_ext;
    logic signed [5:0] bal;      // N1 - N0
    logic signed [5:0] sum;

    tmds_choice u_choice (
        .data_i (bus.data_in),
        .qm_o   (qm_d)
    );

    // Stage 1: transition-minimised word and its side-band bits
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            qm_q   <= '0;
            ve_q   <= 1'b0;
            ctrl_q <= '0;
        end else begin
            qm_q   <= qm_d;
            ve_q   <= bus.ve_in;
            ctrl_q <= bus.control_in;
        end
    end

    // Stage 2 next-state: DC balancing or token insertion
    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, qm_q[i]};
        end
        // Tally arithmetic is carried at 6 bits so intermediate sums never wrap.
        t_ext   = signed'({tally_q[4], tally_q});
        bal     = signed'({1'b0, n1, 1'b0}) - 6'sd8;
        sum     = t_ext;
        tmds_d  = '0;
        tally_d = '0;

        if (!ve_q) begin
            case (ctrl_q)
                2'b00:   tmds_d = 10'b1101010100;
                2'b01:   tmds_d = 10'b0010101011;
                2'b10:   tmds_d = 10'b0101010100;
                default: tmds_d = 10'b1010101011;
            endcase
            tally_d = '0;
        end else begin
            if ((tally_q == 5'd0) || (n1 == 4'd4)) begin
                tmds_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
                sum    = qm_q[8] ? (t_ext + bal) : (t_ext - bal);
            end else if ((!tally_q[4] && (n1 > 4'd4)) || (tally_q[4] && (n1 < 4'd4))) begin
                // Symbol would push disparity further from zero: invert it.
                tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                sum    = t_ext + (qm_q[8] ? 6'sd2 : 6'sd0) - bal;
            end else begin
                tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                sum    = t_ext - (qm_q[8] ? 6'sd0 : 6'sd2) + bal;
            end
            tally_d = sum[4:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tmds_q  <= '0;
            tally_q <= '0;
        end else begin
            tmds_q  <= tmds_d;
            tally_q <= tally_d;
        end
    end

    assign bus.tmds_out  = tmds_q;
    assign bus.tally_out = tally_q;
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder
// Directed bench for tmds_encoder. Each step() drives a new input on a falling
// edge, waits one cycle, then checks the symbol produced by the input driven
// on the previous step (two-stage latency).
module tb_tmds_encoder;
    logic clk_in;
    logic rst_in;
    int   checks;
    int   failures;

    tmds_encoder_if bus ();

    tmds_encoder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [9:0] exp_tmds, input logic [4:0] exp_tally);
        checks++;
        assert (bus.tmds_out === exp_tmds) else begin
            failures++;
            $error("FAIL %s tmds_out observed=%h expected=%h", tag, bus.tmds_out, exp_tmds);
        end
        checks++;
        assert (bus.tally_out === exp_tally) else begin
            failures++;
            $error("FAIL %s tally_out observed=%h expected=%h", tag, bus.tally_out, exp_tally);
        end
    endtask

    // Drive new inputs now (at a falling edge), advance one cycle, then check
    // the symbol belonging to the previous step's input.
    task automatic step(input logic ve, input logic [7:0] d, input logic [1:0] c,
                        input logic [9:0] exp_tmds, input logic [4:0] exp_tally,
                        input string tag);
        bus.ve_in      = ve;
        bus.data_in    = d;
        bus.control_in = c;
        @(negedge clk_in);
        chk(tag, exp_tmds, exp_tally);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_in         = 1'b1;
        bus.ve_in      = 1'b0;
        bus.data_in    = 8'h00;
        bus.control_in = 2'b00;

        repeat (3) @(negedge clk_in);
        chk("reset_state", 10'h000, 5'h00);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("first_after_release", 10'h354, 5'h00);

        // Control tokens; data_in is junk and must be ignored
        step(1'b0, 8'hA5, 2'b00, 10'h354, 5'h00, "tok00_pre");
        step(1'b0, 8'h5A, 2'b01, 10'h354, 5'h00, "tok00");
        step(1'b0, 8'hFF, 2'b10, 10'h0AB, 5'h00, "tok01");
        step(1'b0, 8'h3C, 2'b11, 10'h154, 5'h00, "tok10");
        // Zeros from T=0; control_in is junk and must be ignored
        step(1'b1, 8'h00, 2'b11, 10'h2AB, 5'h00, "tok11");
        step(1'b1, 8'h00, 2'b10, 10'h100, 5'h18, "zero_a");
        step(1'b0, 8'h00, 2'b00, 10'h3FF, 5'h02, "zero_b");
        // All ones from T=0 after a token
        step(1'b1, 8'hFF, 2'b01, 10'h354, 5'h00, "tok_clears_tally");
        step(1'b1, 8'hFF, 2'b00, 10'h200, 5'h18, "ones_a");
        step(1'b0, 8'h12, 2'b11, 10'h0FF, 5'h1E, "ones_b");
        // Alternating ve: every data symbol starts from T=0
        step(1'b1, 8'hFF, 2'b00, 10'h2AB, 5'h00, "alt_tok1");
        step(1'b0, 8'h00, 2'b11, 10'h200, 5'h18, "alt_dat1");
        step(1'b1, 8'hFF, 2'b00, 10'h2AB, 5'h00, "alt_tok2");
        step(1'b0, 8'h00, 2'b11, 10'h200, 5'h18, "alt_dat2");
        // Mixed data: tie rule in the first stage and all three balance cases
        step(1'b1, 8'h0F, 2'b00, 10'h2AB, 5'h00, "alt_tok3");
        step(1'b1, 8'hF0, 2'b00, 10'h105, 5'h1C, "d0F_caseA");
        step(1'b1, 8'h55, 2'b00, 10'h0FA, 5'h1E, "dF0_else");
        step(1'b1, 8'h10, 2'b00, 10'h133, 5'h1E, "d55_balanced");
        step(1'b1, 8'h10, 2'b00, 10'h1F0, 5'h1E, "d10_a");
        step(1'b1, 8'hFF, 2'b00, 10'h1F0, 5'h1E, "d10_b");
        step(1'b1, 8'hFF, 2'b00, 10'h0FF, 5'h04, "dFF_neg_else");
        step(1'b1, 8'h00, 2'b00, 10'h200, 5'h1C, "dFF_pos_caseB");
        step(1'b1, 8'hF0, 2'b00, 10'h3FF, 5'h06, "d00_neg_caseB");
        step(1'b1, 8'h0F, 2'b00, 10'h205, 5'h02, "dF0_pos_caseB");
        step(1'b1, 8'h00, 2'b00, 10'h105, 5'h1E, "d0F_pos_else");

        // Asynchronous reset mid-video, away from any clock edge
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_reset", 10'h000, 5'h00);
        @(negedge clk_in);
        chk("reset_held", 10'h000, 5'h00);
        bus.ve_in      = 1'b1;
        bus.data_in    = 8'h00;
        bus.control_in = 2'b00;
        rst_in         = 1'b0;
        @(negedge clk_in);
        chk("release_token", 10'h354, 5'h00);
        step(1'b0, 8'h00, 2'b10, 10'h100, 5'h18, "restart_from_zero");
        step(1'b0, 8'h00, 2'b00, 10'h154, 5'h00, "tok10_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
